// File: rtl/pokey_audio_pkg.sv
// Shared widths and the per-channel volume gate for the POKEY audio mixer.
package pokey_audio_pkg;
  localparam int LEVEL_W   = 6;
  localparam int LEVEL_MAX = 60;
  localparam int VOL_W     = 4;

  function automatic logic [LEVEL_W-1:0] vol_gate(input logic tone, input logic [VOL_W-1:0] vol);
    return tone ? {{(LEVEL_W-VOL_W){1'b0}}, vol} : '0;
  endfunction
endpackage

// File: rtl/pokey_sync_bit.sv
// Multi-flop synchroniser for one divider-clocked tone bit into clk179.
// Latency STAGES edges; no backpressure (free-running shift).
module pokey_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk179,
  input  logic init_L,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk179 or negedge init_L) begin
    if (!init_L) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/pokey_audio_mixer.sv
// Mixes four gated channel volumes into a level, drives a 1-bit sigma-delta DAC and a decimated PCM.
// Latency: tone -> level SYNC_STAGES+1 edges, level -> dac_out 1 edge; no backpressure (pcm_valid is a strobe).
module pokey_audio_mixer
  import pokey_audio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DECIM_LOG2  = 5
) (
  input  logic                            clk179,
  input  logic                            init_L,
  input  logic                            enable,
  input  logic                            audio1,
  input  logic                            audio2,
  input  logic                            audio3,
  input  logic                            audio4,
  input  logic [VOL_W-1:0]                vol1,
  input  logic [VOL_W-1:0]                vol2,
  input  logic [VOL_W-1:0]                vol3,
  input  logic [VOL_W-1:0]                vol4,
  output logic [LEVEL_W-1:0]              level,
  output logic                            dac_out,
  output logic [LEVEL_W+DECIM_LOG2-1:0]   pcm,
  output logic                            pcm_valid
);
  localparam int PCM_W = LEVEL_W + DECIM_LOG2;

  logic [3:0] audio_s;

  pokey_sync_bit #(.STAGES(SYNC_STAGES)) u_sync1 (.clk179(clk179), .init_L(init_L), .d(audio1), .q(audio_s[0]));
  pokey_sync_bit #(.STAGES(SYNC_STAGES)) u_sync2 (.clk179(clk179), .init_L(init_L), .d(audio2), .q(audio_s[1]));
  pokey_sync_bit #(.STAGES(SYNC_STAGES)) u_sync3 (.clk179(clk179), .init_L(init_L), .d(audio3), .q(audio_s[2]));
  pokey_sync_bit #(.STAGES(SYNC_STAGES)) u_sync4 (.clk179(clk179), .init_L(init_L), .d(audio4), .q(audio_s[3]));

  logic [LEVEL_W-1:0]    level_q,   level_d;
  logic [LEVEL_W-1:0]    sdm_q,     sdm_d;
  logic                  dac_q,     dac_d;
  logic [DECIM_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [PCM_W-1:0]      win_acc_q, win_acc_d;
  logic [PCM_W-1:0]      pcm_q,     pcm_d;
  logic                  pcm_vld_q, pcm_vld_d;
  logic [LEVEL_W:0]      sdm_sum;
  logic [PCM_W-1:0]      win_sum;

  always_comb begin
    level_d = '0;
    if (enable) begin
      level_d = vol_gate(audio_s[0], vol1) + vol_gate(audio_s[1], vol2)
              + vol_gate(audio_s[2], vol3) + vol_gate(audio_s[3], vol4);
    end

    // Carry out of the accumulator is the DAC bit: ones-density = level/64.
    sdm_sum = {1'b0, sdm_q} + {1'b0, level_q};
    sdm_d   = sdm_sum[LEVEL_W-1:0];
    dac_d   = sdm_sum[LEVEL_W];

    win_sum   = win_acc_q + PCM_W'(level_q);
    win_cnt_d = win_cnt_q + DECIM_LOG2'(1);
    win_acc_d = win_sum;
    pcm_d     = pcm_q;
    pcm_vld_d = 1'b0;
    if (win_cnt_q == '1) begin
      pcm_d     = win_sum;
      pcm_vld_d = 1'b1;
      win_acc_d = '0;
    end
  end

  always_ff @(posedge clk179 or negedge init_L) begin
    if (!init_L) begin
      level_q   <= '0;
      sdm_q     <= '0;
      dac_q     <= 1'b0;
      win_cnt_q <= '0;
      win_acc_q <= '0;
      pcm_q     <= '0;
      pcm_vld_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      sdm_q     <= sdm_d;
      dac_q     <= dac_d;
      win_cnt_q <= win_cnt_d;
      win_acc_q <= win_acc_d;
      pcm_q     <= pcm_d;
      pcm_vld_q <= pcm_vld_d;
    end
  end

  assign level     = level_q;
  assign dac_out   = dac_q;
  assign pcm       = pcm_q;
  assign pcm_valid = pcm_vld_q;
endmodule

// File: tb/tb_pokey_audio_mixer.sv
// Self-checking bench for pokey_audio_mixer: constant-input vector table plus randomized and corner sequences.
module tb_pokey_audio_mixer;
  logic        clk179 = 1'b0;
  logic        init_L;
  logic        enable;
  logic [3:0]  aud;
  logic [3:0]  vol [4];
  logic [5:0]  level;
  logic        dac_out;
  logic [10:0] pcm;
  logic        pcm_valid;

  always #5 clk179 = ~clk179;

  pokey_audio_mixer #(.SYNC_STAGES(2), .DECIM_LOG2(5)) dut (
    .clk179(clk179), .init_L(init_L), .enable(enable),
    .audio1(aud[0]), .audio2(aud[1]), .audio3(aud[2]), .audio4(aud[3]),
    .vol1(vol[0]), .vol2(vol[1]), .vol3(vol[2]), .vol4(vol[3]),
    .level(level), .dac_out(dac_out), .pcm(pcm), .pcm_valid(pcm_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, expressed in cycles since release and running sums.
  int       cyc;
  int       lvl_m;
  int       s_acc;
  int       win;
  int       exp_dac;
  int       exp_pcm;
  int       exp_vld;
  logic [3:0] aud_m1, aud_m2;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc = 0; lvl_m = 0; s_acc = 0; win = 0;
    exp_dac = 0; exp_pcm = 0; exp_vld = 0;
    aud_m1 = '0; aud_m2 = '0;
  endtask

  task automatic tick();
    int new_lvl;
    int s_new;
    @(posedge clk179);
    new_lvl = 0;
    if (enable) for (int i = 0; i < 4; i++) if (aud_m2[i]) new_lvl += int'(vol[i]);
    s_new   = s_acc + lvl_m;
    exp_dac = (s_new / 64) - (s_acc / 64);
    s_acc   = s_new;
    win    += lvl_m;
    if (cyc % 32 == 31) begin
      exp_pcm = win; exp_vld = 1; win = 0;
    end else begin
      exp_vld = 0;
    end
    aud_m2 = aud_m1;
    aud_m1 = aud;
    lvl_m  = new_lvl;
    cyc++;
    @(negedge clk179);
    check("level", int'(level), lvl_m);
    check("dac_out", int'(dac_out), exp_dac);
    check("pcm", int'(pcm), exp_pcm);
    check("pcm_valid", int'(pcm_valid), exp_vld);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_dac"}, int'(dac_out), 0);
    check({tag, "_pcm"}, int'(pcm), 0);
    check({tag, "_vld"}, int'(pcm_valid), 0);
  endtask

  // Called just after a negedge; asserts reset mid-cycle, holds n edges, releases on a negedge.
  task automatic apply_reset(input int n);
    #2 init_L = 1'b0;
    #1 check_zero("rst_async");
    repeat (n) @(posedge clk179);
    @(negedge clk179);
    check_zero("rst_hold");
    init_L = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [15:0] vols;
    logic [3:0]  audv;
    logic        en;
    int          exp_level;
    int          exp_pcm;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int ticks;
    int ones;
    tbl[0] = '{16'hFFFF, 4'hF,    1'b1, 60, 1920};
    tbl[1] = '{16'h0008, 4'h1,    1'b1,  8,  256};
    tbl[2] = '{16'h0000, 4'hF,    1'b1,  0,    0};
    tbl[3] = '{16'hFFFF, 4'hF,    1'b0,  0,    0};
    tbl[4] = '{16'h4321, 4'hF,    1'b1, 10,  320};
    tbl[5] = '{16'h137F, 4'b0101, 1'b1, 18,  576};

    init_L = 1'b0; enable = 1'b0; aud = '0;
    for (int i = 0; i < 4; i++) vol[i] = '0;
    model_reset();
    repeat (3) @(posedge clk179);
    @(negedge clk179);
    check_zero("reset");
    init_L = 1'b1;

    // Constant-input vectors: steady level, window sum and DAC density.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) vol[i] = tbl[v].vols[4*i +: 4];
      aud    = tbl[v].audv;
      enable = tbl[v].en;
      ticks  = 0;
      while (ticks < 40 || (cyc % 32) != 0) begin
        tick();
        ticks++;
      end
      check("tbl_level", int'(level), tbl[v].exp_level);
      check("tbl_pcm", int'(pcm), tbl[v].exp_pcm);
      check("tbl_vld", int'(pcm_valid), 1);
      ones = 0;
      for (int k = 0; k < 64; k++) begin
        tick();
        ones += int'(dac_out);
      end
      check("tbl_dac_density", ones, tbl[v].exp_level);
    end

    // 50% square on channel 2, period 10 cycles, vol 10: window sum stays near 160.
    for (int i = 0; i < 4; i++) vol[i] = '0;
    vol[1] = 4'd10; enable = 1'b1;
    for (int t = 0; t < 200; t++) begin
      aud = {2'b00, 1'(((t / 5) % 2)), 1'b0};
      tick();
      if (t >= 40 && pcm_valid)
        check("square_pcm_band", int'(pcm >= 11'd150 && pcm <= 11'd170), 1);
    end

    // Enable dropped and restored within one window.
    while ((cyc % 32) != 0) tick();
    for (int i = 0; i < 4; i++) vol[i] = 4'd15;
    aud = 4'hF;
    for (int t = 0; t < 64; t++) begin
      enable = !(t >= 5 && t < 11);
      tick();
    end
    check("en_toggle_pcm", int'(pcm), 1920);

    // Reset asserted mid-window: window discarded, cadence restarts.
    while ((cyc % 32) != 10) tick();
    apply_reset(2);
    for (int t = 0; t < 40; t++) tick();

    // Randomized inputs against the model.
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(7) == 0)
        for (int i = 0; i < 4; i++) vol[i] = 4'($urandom_range(15));
      aud    = 4'($urandom_range(15));
      enable = ($urandom_range(7) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
